// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo ALU reservation station: widths, the opcode
// enum, the entry record and the CDB tag-match helper.
package tomasulo_pkg;

  localparam int TAG_W = 5;
  localparam int XLEN  = 32;
  localparam int OP_W  = 4;

  localparam logic [TAG_W-1:0] TAG_NONE = 5'd0;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic             busy;
    alu_op_e          op;
    logic [TAG_W-1:0] dest_tag;
    logic [TAG_W-1:0] qj;
    logic [XLEN-1:0]  vj;
    logic [TAG_W-1:0] qk;
    logic [XLEN-1:0]  vk;
  } rs_entry_t;

  // Tag 0 means "value already present", so it can never be woken by the CDB.
  function automatic logic tag_hit(input logic             cdb_valid,
                                   input logic [TAG_W-1:0] cdb_tag,
                                   input logic [TAG_W-1:0] q);
    return cdb_valid && (cdb_tag != TAG_NONE) && (q == cdb_tag);
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB snoop and ALU issue signals of the reservation station.
interface alu_reservation_station_if;
  import tomasulo_pkg::*;

  logic             disp_valid;
  logic             disp_ready;
  logic [OP_W-1:0]  disp_op;
  logic [TAG_W-1:0] disp_dest_tag;
  logic [TAG_W-1:0] disp_qj;
  logic [XLEN-1:0]  disp_vj;
  logic [TAG_W-1:0] disp_qk;
  logic [XLEN-1:0]  disp_vk;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;

  logic             issue_valid;
  logic             issue_ready;
  logic [OP_W-1:0]  issue_op;
  logic [TAG_W-1:0] issue_dest_tag;
  logic [XLEN-1:0]  issue_vj;
  logic [XLEN-1:0]  issue_vk;

  modport master (
    output disp_valid, disp_op, disp_dest_tag, disp_qj, disp_vj, disp_qk, disp_vk,
    output cdb_valid, cdb_tag, cdb_value,
    output issue_ready,
    input  disp_ready,
    input  issue_valid, issue_op, issue_dest_tag, issue_vj, issue_vk
  );

  modport slave (
    input  disp_valid, disp_op, disp_dest_tag, disp_qj, disp_vj, disp_qk, disp_vk,
    input  cdb_valid, cdb_tag, cdb_value,
    input  issue_ready,
    output disp_ready,
    output issue_valid, issue_op, issue_dest_tag, issue_vj, issue_vk
  );

endinterface

// File: rtl/rs_prio_select.sv
// Lowest-index one-hot picker: grants the least significant set request bit.
module rs_prio_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]                           req_i,
  output logic [N-1:0]                           gnt_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   idx_o,
  output logic                                   any_o
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Two's complement isolates the lowest set bit without a priority chain.
  assign gnt_o = req_i & (~req_i + {{(N-1){1'b0}}, 1'b1});
  assign any_o = |req_i;

  // Encode the one-hot grant into an index.
  always_comb begin
    idx_o = {IDX_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx_o = idx_o | (gnt_o[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched micro-ops, snoops the CDB for
// missing operands and issues the lowest-index ready entry to the ALU.
module alu_reservation_station
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  alu_reservation_station_if.slave    rs_if,
  output logic [$clog2(DEPTH):0]      occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rs_entry_t        entries_q [DEPTH];
  rs_entry_t        entries_d [DEPTH];
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_d;

  logic [DEPTH-1:0] busy_s;
  logic [DEPTH-1:0] ready_s;
  logic [DEPTH-1:0] free_gnt_s;
  logic [DEPTH-1:0] ready_gnt_s;
  logic [IDX_W-1:0] free_idx_s;
  logic [IDX_W-1:0] ready_idx_s;
  logic             free_any_s;
  logic             ready_any_s;
  logic             disp_fire_s;
  logic             issue_fire_s;
  rs_entry_t        new_entry_s;
  rs_entry_t        sel_entry_s;

  // Wakeup and dispatch bypass share one operand-capture rule.
  function automatic rs_entry_t capture(input rs_entry_t        e,
                                        input logic             cv,
                                        input logic [TAG_W-1:0] tag,
                                        input logic [XLEN-1:0]  value);
    rs_entry_t r;
    r = e;
    if (tag_hit(cv, tag, e.qj)) begin
      r.qj = TAG_NONE;
      r.vj = value;
    end else begin
      r.qj = e.qj;
    end
    if (tag_hit(cv, tag, e.qk)) begin
      r.qk = TAG_NONE;
      r.vk = value;
    end else begin
      r.qk = e.qk;
    end
    return r;
  endfunction

  // Per-entry busy and ready flags.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy_s[i]  = entries_q[i].busy;
      ready_s[i] = entries_q[i].busy &&
                   (entries_q[i].qj == TAG_NONE) && (entries_q[i].qk == TAG_NONE);
    end
  end

  rs_prio_select #(.N(DEPTH)) u_free_sel (
    .req_i (~busy_s),
    .gnt_o (free_gnt_s),
    .idx_o (free_idx_s),
    .any_o (free_any_s)
  );

  rs_prio_select #(.N(DEPTH)) u_ready_sel (
    .req_i (ready_s),
    .gnt_o (ready_gnt_s),
    .idx_o (ready_idx_s),
    .any_o (ready_any_s)
  );

  assign rs_if.disp_ready = (occ_q < CNT_W'(DEPTH));
  assign disp_fire_s      = rs_if.disp_valid && rs_if.disp_ready && !flush;
  assign issue_fire_s     = ready_any_s && rs_if.issue_ready;

  // Assemble the incoming entry before bypass capture.
  always_comb begin
    new_entry_s          = '0;
    new_entry_s.busy     = 1'b1;
    new_entry_s.op       = alu_op_e'(rs_if.disp_op);
    new_entry_s.dest_tag = rs_if.disp_dest_tag;
    new_entry_s.qj       = rs_if.disp_qj;
    new_entry_s.vj       = rs_if.disp_vj;
    new_entry_s.qk       = rs_if.disp_qk;
    new_entry_s.vk       = rs_if.disp_vk;
  end

  // Next-state entries: a free slot can never be the issuing slot, so the
  // dispatch and issue branches never collide on the same index.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        entries_d[i] = '0;
      end else if (disp_fire_s && free_gnt_s[i]) begin
        entries_d[i] = capture(new_entry_s, rs_if.cdb_valid, rs_if.cdb_tag, rs_if.cdb_value);
      end else if (issue_fire_s && ready_gnt_s[i]) begin
        entries_d[i] = '0;
      end else if (entries_q[i].busy) begin
        entries_d[i] = capture(entries_q[i], rs_if.cdb_valid, rs_if.cdb_tag, rs_if.cdb_value);
      end else begin
        entries_d[i] = entries_q[i];
      end
    end
  end

  // Occupancy moves by +1, 0 or -1 unless flushed.
  always_comb begin
    if (flush) begin
      occ_d = {CNT_W{1'b0}};
    end else begin
      occ_d = occ_q + CNT_W'(disp_fire_s) - CNT_W'(issue_fire_s);
    end
  end

  // Entry array and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      occ_q <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      occ_q <= occ_d;
    end
  end

  assign sel_entry_s = entries_q[ready_idx_s];

  // Issue port is zeroed whenever nothing is ready.
  always_comb begin
    if (ready_any_s) begin
      rs_if.issue_valid    = 1'b1;
      rs_if.issue_op       = sel_entry_s.op;
      rs_if.issue_dest_tag = sel_entry_s.dest_tag;
      rs_if.issue_vj       = sel_entry_s.vj;
      rs_if.issue_vk       = sel_entry_s.vk;
    end else begin
      rs_if.issue_valid    = 1'b0;
      rs_if.issue_op       = {OP_W{1'b0}};
      rs_if.issue_dest_tag = {TAG_W{1'b0}};
      rs_if.issue_vj       = {XLEN{1'b0}};
      rs_if.issue_vk       = {XLEN{1'b0}};
    end
  end

  assign occupancy = occ_q;

  logic unused_s;
  assign unused_s = free_any_s ^ (|free_idx_s);

endmodule
